mc_ctrl: RTL and testbench

- Multi-cycle control sequencer for the yIF/yID/yEX datapath plus data memory.
- Owns the PC and instruction register, and steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Decodes the latched instruction into RegWrite, ALUSrc, op, memory strobes and PC select.
- Replaces hand-written per-instruction control in benches; sits between the datapath blocks and the top level.

---
 rtl/mc_ctrl_pkg.sv | 47 ++++
 rtl/mc_ctrl_decode.sv | 60 ++++++
 rtl/mc_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU = 3'd0,
        CLS_LW  = 3'd1,
        CLS_SW  = 3'd2,
        CLS_BEQ = 3'd3,
        CLS_JAL = 3'd4
    } cls_t;

    localparam logic [6:0] OP_R   = 7'h33;
    localparam logic [6:0] OP_I   = 7'h13;
    localparam logic [6:0] OP_LW  = 7'h03;
    localparam logic [6:0] OP_SW  = 7'h23;
    localparam logic [6:0] OP_BEQ = 7'h63;
    localparam logic [6:0] OP_JAL = 7'h6F;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // funct3 to ALU op for the non-add/sub encodings shared by R and I types
    function automatic logic [2:0] funct3_alu(input logic [2:0] funct3);
        logic [2:0] res;
        case (funct3)
            3'b111:  res = ALU_AND;
            3'b110:  res = ALU_OR;
            3'b010:  res = ALU_SLT;
            default: res = ALU_ADD;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decoder: class, ALU op, B-input select and validity.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output cls_t        cls,
    output logic [2:0]  op,
    output logic        alu_src,
    output logic        valid
);

    logic unused_s;
    assign unused_s = ^{ir[31], ir[29:15], ir[11:7]};

    // Opcode/funct decode; unknown opcodes fall through with valid low
    always_comb begin
        cls     = CLS_ALU;
        op      = ALU_ADD;
        alu_src = 1'b0;
        valid   = 1'b0;
        case (ir[6:0])
            OP_R: begin
                valid = 1'b1;
                if (ir[14:12] == 3'b000) begin
                    op = ir[30] ? ALU_SUB : ALU_ADD;
                end else begin
                    op = funct3_alu(ir[14:12]);
                end
            end
            OP_I: begin
                valid   = 1'b1;
                alu_src = 1'b1;
                op      = funct3_alu(ir[14:12]);
            end
            OP_LW: begin
                valid   = 1'b1;
                cls     = CLS_LW;
                alu_src = 1'b1;
            end
            OP_SW: begin
                valid   = 1'b1;
                cls     = CLS_SW;
                alu_src = 1'b1;
            end
            OP_BEQ: begin
                valid = 1'b1;
                cls   = CLS_BEQ;
                op    = ALU_SUB;
            end
            OP_JAL: begin
                valid = 1'b1;
                cls   = CLS_JAL;
            end
            default: begin
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer: owns PC, IR and retire counter and steps
// each instruction through FETCH/DECODE/EXEC/MEM/WB with registered strobes.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter logic [31:0] ENTRY_PC  = 32'h0000_0028,
    parameter int          MAX_INSNS = 16,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      ins,
    input  logic [31:0]      imm,
    input  logic             zero,
    output logic [31:0]      pc,
    output logic [31:0]      ir,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic [2:0]       op,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Mem2Reg,
    output logic             link,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t            state_r;
    logic [31:0]       pc_r;
    logic [31:0]       ir_r;
    logic [CNT_W-1:0]  retired_r;
    logic              reg_write_r;
    logic              mem_read_r;
    logic              mem_write_r;
    logic              mem2reg_r;
    logic              link_r;
    logic              busy_r;
    logic              halted_r;
    logic              illegal_r;

    cls_t              cls_s;
    logic [2:0]        op_s;
    logic              alu_src_s;
    logic              valid_s;
    logic [31:0]       pc_next_s;
    logic [CNT_W-1:0]  retired_inc_s;
    logic              halt_next_s;
    state_t            after_s;

    mc_ctrl_decode u_decode (
        .ir      (ir_r),
        .cls     (cls_s),
        .op      (op_s),
        .alu_src (alu_src_s),
        .valid   (valid_s)
    );

    // Values committed on the edge that retires an instruction
    always_comb begin
        if (retired_r != {CNT_W{1'b1}}) begin
            retired_inc_s = retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retired_inc_s = retired_r;
        end
        halt_next_s = (MAX_INSNS != 32'sd0) && (retired_inc_s == CNT_W'(MAX_INSNS));
        if (((cls_s == CLS_BEQ) && zero) || (cls_s == CLS_JAL)) begin
            pc_next_s = pc_r + imm;
        end else begin
            pc_next_s = pc_r + 32'd4;
        end
        after_s = halt_next_s ? ST_HALT : ST_FETCH;
    end

    // Sequencer FSM; strobes are registered from the next state so they are
    // glitch-free and cleared asynchronously by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            pc_r        <= ENTRY_PC;
            ir_r        <= 32'd0;
            retired_r   <= {CNT_W{1'b0}};
            reg_write_r <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            mem2reg_r   <= 1'b0;
            link_r      <= 1'b0;
            busy_r      <= 1'b0;
            halted_r    <= 1'b0;
            illegal_r   <= 1'b0;
        end else begin
            reg_write_r <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            mem2reg_r   <= 1'b0;
            link_r      <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r   <= ST_FETCH;
                        pc_r      <= ENTRY_PC;
                        retired_r <= {CNT_W{1'b0}};
                        illegal_r <= 1'b0;
                        busy_r    <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    ir_r    <= ins;
                    state_r <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (!valid_s) begin
                        state_r   <= ST_HALT;
                        illegal_r <= 1'b1;
                        busy_r    <= 1'b0;
                        halted_r  <= 1'b1;
                    end else begin
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (cls_s)
                        CLS_LW: begin
                            state_r    <= ST_MEM;
                            mem_read_r <= 1'b1;
                        end
                        CLS_SW: begin
                            state_r     <= ST_MEM;
                            mem_write_r <= 1'b1;
                        end
                        CLS_BEQ: begin
                            state_r   <= after_s;
                            pc_r      <= pc_next_s;
                            retired_r <= retired_inc_s;
                            busy_r    <= !halt_next_s;
                            halted_r  <= halt_next_s;
                        end
                        CLS_JAL: begin
                            state_r     <= ST_WB;
                            reg_write_r <= 1'b1;
                            link_r      <= 1'b1;
                        end
                        default: begin
                            state_r     <= ST_WB;
                            reg_write_r <= 1'b1;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (cls_s == CLS_LW) begin
                        state_r     <= ST_WB;
                        reg_write_r <= 1'b1;
                        mem2reg_r   <= 1'b1;
                    end else begin
                        state_r   <= after_s;
                        pc_r      <= pc_next_s;
                        retired_r <= retired_inc_s;
                        busy_r    <= !halt_next_s;
                        halted_r  <= halt_next_s;
                    end
                end
                ST_WB: begin
                    state_r   <= after_s;
                    pc_r      <= pc_next_s;
                    retired_r <= retired_inc_s;
                    busy_r    <= !halt_next_s;
                    halted_r  <= halt_next_s;
                end
                ST_HALT: begin
                    if (start) begin
                        state_r  <= ST_IDLE;
                        halted_r <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    busy_r   <= 1'b0;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    assign pc       = pc_r;
    assign ir       = ir_r;
    assign retired  = retired_r;
    assign RegWrite = reg_write_r;
    assign MemRead  = mem_read_r;
    assign MemWrite = mem_write_r;
    assign Mem2Reg  = mem2reg_r;
    assign link     = link_r;
    assign busy     = busy_r;
    assign halted   = halted_r;
    assign illegal  = illegal_r;
    assign op       = op_s;
    assign ALUSrc   = alu_src_s;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-cycle expectations from an
// instruction-level model plus directed literal checks and random programs.
module tb_mc_ctrl;

    localparam logic [31:0] ENTRY = 32'h0000_0028;
    localparam int          MAXI  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] ins = 32'd0;
    logic [31:0] imm = 32'd0;
    logic [31:0] pc, ir;
    logic        RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, link, busy, halted, illegal;
    logic [2:0]  op;
    logic [15:0] retired;

    mc_ctrl #(.ENTRY_PC(ENTRY), .MAX_INSNS(MAXI), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ins(ins), .imm(imm), .zero(zero),
        .pc(pc), .ir(ir), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .op(op),
        .MemRead(MemRead), .MemWrite(MemWrite), .Mem2Reg(Mem2Reg), .link(link),
        .busy(busy), .halted(halted), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [91:0] v;
        logic [91:0] m;
    } exp_t;

    exp_t        q[$];
    int          nvec = 0;
    int          nerr = 0;
    int          cyc = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic [15:0] m_ret;
    logic        m_ill;

    exp_t        ce;
    logic [91:0] act_v;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n && q.size() > 0) begin
            ce = q.pop_front();
            act_v = {pc, ir, retired, RegWrite, MemRead, MemWrite, Mem2Reg, link,
                     busy, halted, illegal, ALUSrc, op};
            nvec = nvec + 1;
            if (((act_v ^ ce.v) & ce.m) != 92'd0) begin
                nerr = nerr + 1;
                $display("FAIL cycle %0d outputs: got %h want %h (mask %h)", cyc, act_v, ce.v, ce.m);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec = nvec + 1;
        if (act !== exp) begin
            nerr = nerr + 1;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // flags are {RegWrite,MemRead,MemWrite,Mem2Reg,link,busy,halted,illegal}
    task automatic push(input logic [7:0] fl, input logic [3:0] dec, input logic [3:0] dmask);
        exp_t e;
        e.v = {m_pc, m_ir, m_ret, fl, dec};
        e.m = {{88{1'b1}}, dmask};
        q.push_back(e);
    endtask

    function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  return sub ? 3'b110 : 3'b010;
            3'b111:  return 3'b000;
            3'b110:  return 3'b001;
            3'b010:  return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    // kind: 0 R/I, 1 lw, 2 sw, 3 beq, 4 jal
    task automatic ref_dec(input logic [31:0] i, output bit valid, output int kind,
                           output int len, output logic [3:0] dec, output logic [3:0] dmask);
        valid = 1'b1; dmask = 4'hF; dec = 4'b0010; kind = 0; len = 4;
        case (i[6:0])
            7'h33: dec = {1'b0, alu_of(i[14:12], i[30])};
            7'h13: dec = {1'b1, alu_of(i[14:12], 1'b0)};
            7'h03: begin dec = 4'b1010; kind = 1; len = 5; end
            7'h23: begin dec = 4'b1010; kind = 2; end
            7'h63: begin dec = 4'b0110; kind = 3; len = 3; end
            7'h6F: begin dec = 4'b0010; kind = 4; dmask = 4'h7; end
            default: begin valid = 1'b0; dmask = 4'h0; len = 2; end
        endcase
    endtask

    // {RegWrite,MemRead,MemWrite,Mem2Reg,link} during cycle k of a class
    function automatic logic [4:0] strobes(input int kind, input int k);
        if (k == 4) begin
            case (kind)
                0:       return 5'b10000;
                1:       return 5'b01000;
                2:       return 5'b00100;
                4:       return 5'b10001;
                default: return 5'b00000;
            endcase
        end else if (k == 5 && kind == 1) begin
            return 5'b10010;
        end else begin
            return 5'b00000;
        end
    endfunction

    function automatic logic rnd_start();
        return ($urandom_range(0, 7) == 0);
    endfunction

    task automatic run_insn(input logic [31:0] i, input logic [31:0] im, input int zsel,
                            input int abort_k, output bit aborted);
        bit          valid;
        int          kind, len;
        logic [3:0]  dec, dmask;
        logic        z = 1'b0;
        aborted = 1'b0;
        ref_dec(i, valid, kind, len, dec, dmask);
        ins = i; imm = im; start = rnd_start(); zero = $urandom_range(0, 1);
        push({5'b00000, 1'b1, 1'b0, m_ill}, 4'h0, 4'h0);
        step();
        m_ir = i; ins = $urandom; start = rnd_start(); zero = $urandom_range(0, 1);
        push({5'b00000, 1'b1, 1'b0, m_ill}, dec, dmask);
        step();
        if (!valid) begin
            m_ill = 1'b1;
            start = 1'b0;
            return;
        end
        for (int k = 3; k <= len; k++) begin
            z = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
            zero = z; start = rnd_start();
            push({strobes(kind, k), 1'b1, 1'b0, 1'b0}, dec, dmask);
            if (k == abort_k) begin
                #6;
                rst_n = 1'b0;
                #1;
                chk("abort_memread", {31'd0, MemRead}, 32'd0);
                chk("abort_strobes", {27'd0, RegWrite, MemWrite, Mem2Reg, link, busy}, 32'd0);
                chk("abort_pc", pc, 32'h28);
                chk("abort_ir", ir, 32'd0);
                aborted = 1'b1;
                start = 1'b0;
                return;
            end
            step();
        end
        start = 1'b0;
        if ((kind == 3 && z) || kind == 4) m_pc = m_pc + im;
        else m_pc = m_pc + 32'd4;
        if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        q.delete();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        m_pc = ENTRY; m_ir = 32'd0; m_ret = 16'd0; m_ill = 1'b0;
    endtask

    task automatic idle_and_start();
        repeat ($urandom_range(0, 2)) begin
            push({5'b00000, 1'b0, 1'b0, m_ill}, 4'h0, 4'h0);
            step();
        end
        start = 1'b1;
        push({5'b00000, 1'b0, 1'b0, m_ill}, 4'h0, 4'h0);
        step();
        start = 1'b0;
        m_pc = ENTRY; m_ret = 16'd0; m_ill = 1'b0;
    endtask

    task automatic restart();
        repeat ($urandom_range(0, 2)) begin
            push({5'b00000, 1'b0, 1'b1, m_ill}, 4'h0, 4'h0);
            step();
        end
        start = 1'b1;
        push({5'b00000, 1'b0, 1'b1, m_ill}, 4'h0, 4'h0);
        step();
        start = 1'b0;
        idle_and_start();
    endtask

    function automatic logic [31:0] gen_ins();
        logic [31:0] body;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [2:0]  f3_tab [4];
        logic [6:0]  bad_tab [5];
        int          r;
        f3_tab = '{3'b000, 3'b111, 3'b110, 3'b010};
        bad_tab = '{7'h00, 7'h37, 7'h17, 7'h67, 7'h7F};
        body = $urandom;
        r = $urandom_range(0, 19);
        f3 = body[14:12];
        if (r < 5) begin opc = 7'h33; f3 = f3_tab[$urandom_range(0, 3)]; end
        else if (r < 9) begin opc = 7'h13; f3 = f3_tab[$urandom_range(0, 3)]; end
        else if (r < 12) opc = 7'h03;
        else if (r < 14) opc = 7'h23;
        else if (r < 17) opc = 7'h63;
        else if (r < 19) opc = 7'h6F;
        else opc = bad_tab[$urandom_range(0, 4)];
        return {body[31:15], f3, body[11:7], opc};
    endfunction

    initial begin
        bit ab;
        do_reset();
        chk("reset_pc", pc, 32'h28);
        chk("reset_ir", ir, 32'd0);
        chk("reset_retired", {16'd0, retired}, 32'd0);
        chk("reset_op_alusrc", {28'd0, ALUSrc, op}, 32'h2);
        chk("reset_flags", {24'd0, RegWrite, MemRead, MemWrite, Mem2Reg, link, busy, halted, illegal}, 32'd0);

        // add, lw, sw: third retire reaches the limit
        idle_and_start();
        run_insn(32'h00628333, $urandom, -1, 0, ab);
        chk("add_ir", ir, 32'h00628333);
        chk("add_pc", pc, 32'h2C);
        chk("add_retired", {16'd0, retired}, 32'd1);
        run_insn(32'h0002A303, $urandom, -1, 0, ab);
        chk("lw_pc", pc, 32'h30);
        run_insn(32'h0062A023, $urandom, -1, 0, ab);
        chk("sw_pc", pc, 32'h34);
        chk("sw_halt", {30'd0, halted, busy}, 32'h2);
        chk("sw_retired", {16'd0, retired}, 32'd3);

        // beq taken then not taken, each from ENTRY
        restart();
        run_insn(32'h00000463, 32'd8, 1, 0, ab);
        chk("beq_taken_pc", pc, 32'h30);
        do_reset();
        idle_and_start();
        run_insn(32'h00000463, 32'd8, 0, 0, ab);
        chk("beq_fall_pc", pc, 32'h2C);

        // three adds then halt, start returns to IDLE
        do_reset();
        idle_and_start();
        repeat (3) run_insn(32'h00628333, $urandom, -1, 0, ab);
        chk("max_halt", {30'd0, halted, busy}, 32'h2);
        chk("max_pc", pc, 32'h34);
        chk("max_retired", {16'd0, retired}, 32'd3);
        start = 1'b1;
        push({5'b00000, 1'b0, 1'b1, 1'b0}, 4'h0, 4'h0);
        step();
        start = 1'b0;
        chk("halt_to_idle", {30'd0, halted, busy}, 32'd0);

        // unknown opcode
        do_reset();
        idle_and_start();
        run_insn(32'h00000000, $urandom, -1, 0, ab);
        chk("illegal_flags", {30'd0, illegal, halted}, 32'h3);
        chk("illegal_pc", pc, 32'h28);
        push({5'b00000, 1'b0, 1'b1, 1'b1}, 4'h0, 4'h0);
        step();

        // reset during the lw MEM cycle
        do_reset();
        idle_and_start();
        run_insn(32'h0002A303, $urandom, -1, 4, ab);
        chk("abort_taken", {31'd0, ab}, 32'd1);
        do_reset();

        // random programs
        idle_and_start();
        for (int n = 0; n < 300; n++) begin
            run_insn(gen_ins(), $urandom, -1, 0, ab);
            if (m_ill || m_ret == 16'(MAXI)) begin
                restart();
            end else if ($urandom_range(0, 39) == 0) begin
                do_reset();
                idle_and_start();
            end
        end
        push({5'b00000, 1'b1, 1'b0, m_ill}, 4'h0, 4'h0);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
